// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the L1-to-bus read arbiter and the caches it serves.
package cpu_defs;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IC,
    OWN_DC
  } arb_owner_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DRAIN
  } mem_arb_state_t;

  // Words per cache line; also the refill burst length.
  localparam int LINE_WORDS = 4;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Cache-side request/response ports and bus-side read channel of the arbiter.
// The master modport is the arbiter's view; slave is the view of the caches and bus.
interface mem_read_arbiter_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_cancel;
  logic        ic_gnt;
  logic        ic_rvalid;
  logic [31:0] ic_rdata;
  logic        ic_rlast;

  logic        dc_req;
  logic [31:0] dc_addr;
  logic        dc_single;
  logic        dc_gnt;
  logic        dc_rvalid;
  logic [31:0] dc_rdata;
  logic        dc_rlast;

  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic [7:0]  mem_arlen;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;
  logic        mem_rready;

  modport master (
    input  ic_req, ic_addr, ic_cancel,
    output ic_gnt, ic_rvalid, ic_rdata, ic_rlast,
    input  dc_req, dc_addr, dc_single,
    output dc_gnt, dc_rvalid, dc_rdata, dc_rlast,
    output mem_arvalid, mem_araddr, mem_arlen, mem_rready,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rlast
  );

  modport slave (
    output ic_req, ic_addr, ic_cancel,
    input  ic_gnt, ic_rvalid, ic_rdata, ic_rlast,
    output dc_req, dc_addr, dc_single,
    input  dc_gnt, dc_rvalid, dc_rdata, dc_rlast,
    input  mem_arvalid, mem_araddr, mem_arlen, mem_rready,
    output mem_arready, mem_rvalid, mem_rdata, mem_rlast
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Shares one external read-burst channel between icache refills and dcache reads,
// one transaction at a time, draining icache bursts abandoned on a pipeline flush.
module mem_read_arbiter
  import cpu_defs::*;
#(
    parameter int LINE_WORDS = cpu_defs::LINE_WORDS,
    parameter int STARVE_LIM = 8
) (
    input logic clk,
    input logic rst_n,
    mem_read_arbiter_if.master io
);

    localparam int          CNT_W     = $clog2(STARVE_LIM + 1);
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
    localparam logic [7:0]  LINE_LEN  = 8'(LINE_WORDS - 1);

    mem_arb_state_t   state, state_d;
    arb_owner_t       owner, owner_d, pick;
    logic [31:0]      addr_q, addr_d, pick_addr;
    logic [7:0]       len_q, len_d, pick_len;
    logic [CNT_W-1:0] starve_cnt, starve_d;
    logic             ic_live, ic_starved, ic_cut, beat_last;

    // A cancelled icache request is invisible to arbitration in the same cycle.
    assign ic_live    = io.ic_req & ~io.ic_cancel;
    assign ic_starved = ic_live && (starve_cnt >= CNT_W'(STARVE_LIM));
    assign ic_cut     = io.ic_cancel && (owner == OWN_IC);
    assign beat_last  = io.mem_rvalid & io.mem_rlast;

    always_comb begin
        pick      = OWN_NONE;
        pick_addr = '0;
        pick_len  = '0;
        if (io.dc_req && !ic_starved) begin
            pick      = OWN_DC;
            pick_addr = io.dc_single ? {io.dc_addr[31:2], 2'b00} : (io.dc_addr & LINE_MASK);
            pick_len  = io.dc_single ? 8'd0 : LINE_LEN;
        end else if (ic_live) begin
            pick      = OWN_IC;
            pick_addr = io.ic_addr & LINE_MASK;
            pick_len  = LINE_LEN;
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d        = state;
        owner_d        = owner;
        addr_d         = addr_q;
        len_d          = len_q;
        io.ic_gnt      = 1'b0;
        io.ic_rvalid   = 1'b0;
        io.ic_rdata    = '0;
        io.ic_rlast    = 1'b0;
        io.dc_gnt      = 1'b0;
        io.dc_rvalid   = 1'b0;
        io.dc_rdata    = '0;
        io.dc_rlast    = 1'b0;
        io.mem_arvalid = 1'b0;
        io.mem_araddr  = '0;
        io.mem_arlen   = '0;
        io.mem_rready  = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick != OWN_NONE) begin
                    owner_d = pick;
                    addr_d  = pick_addr;
                    len_d   = pick_len;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // The address cannot be withdrawn once presented; a cancel only orphans the burst.
                io.mem_arvalid = 1'b1;
                io.mem_araddr  = addr_q;
                io.mem_arlen   = len_q;
                if (ic_cut) owner_d = OWN_NONE;
                if (io.mem_arready) begin
                    io.ic_gnt = (owner == OWN_IC) && !io.ic_cancel;
                    io.dc_gnt = (owner == OWN_DC);
                    state_d   = ((owner == OWN_NONE) || ic_cut) ? DRAIN : DATA;
                end
            end
            DATA: begin
                io.mem_rready = 1'b1;
                if (owner == OWN_IC && !io.ic_cancel) begin
                    io.ic_rvalid = io.mem_rvalid;
                    io.ic_rdata  = io.mem_rdata;
                    io.ic_rlast  = beat_last;
                end
                if (owner == OWN_DC) begin
                    io.dc_rvalid = io.mem_rvalid;
                    io.dc_rdata  = io.mem_rdata;
                    io.dc_rlast  = beat_last;
                end
                if (beat_last) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end else if (ic_cut) begin
                    state_d = DRAIN;
                    owner_d = OWN_NONE;
                end
            end
            DRAIN: begin
                io.mem_rready = 1'b1;
                if (beat_last) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_cnt;
        if (io.ic_gnt || io.ic_cancel) starve_d = '0;
        else if (io.ic_req && (starve_cnt < CNT_W'(STARVE_LIM))) starve_d = starve_cnt + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            addr_q     <= '0;
            len_q      <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            starve_cnt <= starve_d;
        end
    end

endmodule
